dmem_lsu: RTL
=============

Name: dmem_lsu

Overview:
- Load/store unit sitting directly upstream of the data memory.
- Accepts one load or store per transaction from the core over a valid/ready handshake.
- Computes the effective address, then checks alignment and range; bad requests never reach the memory.
- Sequences the memory's req/wen/ren/size/zero_ex controls for async or sync read, and returns the result over a valid/ready response channel.

Parameters:
- WIDTH, 32, data word width.
- DEPTH, 16, memory depth in bytes; AW = $clog2(DEPTH).
- SYNC_READ, 0, must equal the memory's SYNC_READ. 0 = read data valid in the access cycle; 1 = valid one cycle later.

Ports:
- clk in 1: single clock, rising edge.
- res in 1: reset, synchronous, active-high.
- req_valid in 1: core request valid.
- req_ready out 1: unit can accept a request.
- req_we in 1: 1 = store, 0 = load.
- req_size in op_dmem_size: BYTE/HALF/TRPL/WORD.
- req_zero_ex in 1: load zero-extends.
- req_base in 32: base register value.
- req_offset in 12: signed immediate.
- req_wdata in WIDTH: store data.
- rsp_valid out 1: response valid.
- rsp_ready in 1: core accepts the response.
- rsp_rdata out WIDTH: load data; 0 for stores and errors.
- rsp_err out 1: misaligned or out-of-range.
- mem_req, mem_wen, mem_ren out 1 each: memory controls.
- mem_zero_ex out 1, mem_size out op_dmem_size: memory controls.
- mem_addr out AW, mem_wdata out WIDTH: memory address and write data.
- mem_rdata in WIDTH: memory read data, already extended by the memory.

Behaviour:
- Reset and clocking: one clock; reset is synchronous and active-high. While res is sampled high, the next state is IDLE and all registers clear.
- Reset values: every output is 0 in the cycle after a reset edge, except req_ready = 1.
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - When req_valid & req_ready, latch the request and compute ea = req_base + sext(req_offset), mod 2^32.
  - err = misaligned | out_of_range.
  - misaligned: HALF with ea[0]=1; TRPL or WORD with ea[1:0]!=0.
  - out_of_range: ea + bytes(size) - 1 >= DEPTH, where bytes = 1/2/3/4.
  - err=1 -> RESP; otherwise -> ACCESS.
- ACCESS (exactly one cycle):
  - mem_req = 1, mem_wen = st, mem_ren = !st.
  - mem_addr = ea[AW-1:0]; size, zero_ex and wdata come from the latch.
  - Store -> RESP; the write commits on the edge ending ACCESS.
  - Load with SYNC_READ=0: capture mem_rdata at the end of ACCESS -> RESP.
  - Load with SYNC_READ=1 -> WAIT.
- WAIT (SYNC_READ=1 only):
  - mem_req = mem_ren = 0.
  - mem_size and mem_zero_ex stay at the latched values, because the memory's extension logic is combinational on size.
  - Capture mem_rdata -> RESP.
- RESP:
  - rsp_valid = 1; rsp_rdata and rsp_err are held stable until rsp_ready.
  - On rsp_valid & rsp_ready -> IDLE.
  - req_ready = 0; no request overlap.
- Mem-side outputs outside ACCESS/WAIT: mem_req/wen/ren = 0, mem_addr = 0, mem_wdata = 0.
- Latency from accept edge (cycle N) to rsp_valid:
  - store or async load: N+2;
  - sync load: N+3;
  - error: N+1.
- Error requests: zero memory activity; rsp_rdata = 0, rsp_err = 1.
- rsp_ready low: stays in RESP indefinitely with outputs frozen.
- Reset mid-transaction: the transaction is dropped, no response is issued, mem_req is low from the next cycle. A store reset during ACCESS is not guaranteed to commit.
- ea upper bits [31:AW] are ignored only after the range check passes.

Optional Feature:
- Macro: DMEM_LSU_PERF_CNT_EN.
- Defined: adds outputs cnt_load, cnt_store, cnt_err (32 bits each).
  - Each increments by 1 on the RESP handshake of its transaction type; errors count only in cnt_err.
  - Counters wrap at 2^32 and clear on res.
- Undefined: these ports and their logic do not exist.

Decomposition:
- risc_pkg adds:
  - lsu_state_t enum {LSU_IDLE, LSU_ACCESS, LSU_WAIT, LSU_RESP};
  - function dmem_bytes(op_dmem_size) returning 1..4.
- op_dmem_size is reused as-is.
- One sub-module, dmem_addr_chk (combinational): inputs ea and size; outputs misaligned and out_of_range.

Test Plan:
- Aligned word store, then load: base=4, off=0, wdata=0xDEADBEEF, WORD. rsp_valid at N+2 with err=0; load returns 0xDEADBEEF (N+2 async, N+3 with SYNC_READ=1).
- Negative offset with sign-extension: base=8, off=-5 (0xFFB) gives ea=3. Store byte 0x80, then load BYTE zero_ex=0 -> rdata=0xFFFFFF80; zero_ex=1 -> 0x00000080.
- Misaligned: HALF at ea=5 -> rsp_err=1, rdata=0 at N+1, mem_req never asserted. WORD at ea=13 (DEPTH=16) -> err (out of range).
- Backpressure: rsp_ready held low 5 cycles -> rsp_valid, rsp_rdata and rsp_err stable; req_ready=0 throughout; req_valid pulses are ignored.
- Reset mid-op: assert res during ACCESS of a load -> next cycle rsp_valid=0, mem_req=0, req_ready=1; a new request completes normally.
- With DMEM_LSU_PERF_CNT_EN defined, run 3 loads, 2 stores, 1 error -> cnt_load=3, cnt_store=2, cnt_err=1; res clears all three counters.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared core types for the data-memory path: access sizes, LSU states and the size-to-bytes helper.
package risc_pkg;

   typedef enum logic [1:0] {BYTE = 2'd0, HALF = 2'd1, TRPL = 2'd2, WORD = 2'd3} op_dmem_size;

   typedef enum logic [1:0] {LSU_IDLE, LSU_ACCESS, LSU_WAIT, LSU_RESP} lsu_state_t;

   // Size encoding is ordered so the byte count is simply code + 1.
   function automatic logic [2:0] dmem_bytes(op_dmem_size size);
      return 3'(size) + 3'd1;
   endfunction

endpackage

// File: rtl/dmem_lsu_addr_chk.sv
// Combinational alignment and range check of an effective address against the data memory.
module dmem_addr_chk
   import risc_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic [31:0] ea,
   input  op_dmem_size size,
   output logic        misaligned,
   output logic        out_of_range
);

   logic [32:0] last;

   always_comb begin
      misaligned = 1'b0;
      case (size)
         HALF:       misaligned = ea[0];
         TRPL, WORD: misaligned = |ea[1:0];
         default:    misaligned = 1'b0;
      endcase
   end

   // Extra bit keeps the last-byte address from wrapping near 2^32.
   assign last         = {1'b0, ea} + 33'(dmem_bytes(size)) - 33'd1;
   assign out_of_range = last >= 33'(DEPTH);

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit in front of the data memory: one transaction at a time, errors never reach memory.
// Optional DMEM_LSU_PERF_CNT_EN adds load/store/error handshake counters.
module dmem_lsu
   import risc_pkg::*;
#(
   parameter int  WIDTH     = 32,
   parameter int  DEPTH     = 16,
   parameter int  SYNC_READ = 0,
   localparam int AW        = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             res,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_we,
   input  op_dmem_size      req_size,
   input  logic             req_zero_ex,
   input  logic [31:0]      req_base,
   input  logic [11:0]      req_offset,
   input  logic [WIDTH-1:0] req_wdata,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_rdata,
   output logic             rsp_err,
   output logic             mem_req,
   output logic             mem_wen,
   output logic             mem_ren,
   output logic             mem_zero_ex,
   output op_dmem_size      mem_size,
   output logic [AW-1:0]    mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic [WIDTH-1:0] mem_rdata
`ifdef DMEM_LSU_PERF_CNT_EN
   ,
   output logic [31:0]      cnt_load,
   output logic [31:0]      cnt_store,
   output logic [31:0]      cnt_err
`endif
);

   lsu_state_t  state;
   logic        st_q;
   logic [31:0] ea;
   logic        misaligned, out_of_range;

   assign ea = req_base + {{20{req_offset[11]}}, req_offset};

   dmem_addr_chk #(.DEPTH(DEPTH)) u_chk (
      .ea           (ea),
      .size         (req_size),
      .misaligned   (misaligned),
      .out_of_range (out_of_range)
   );

   // The mem_* registers double as the request latch while a transaction is in flight.
   always_ff @(posedge clk) begin
      if (res) begin
         state       <= LSU_IDLE;
         st_q        <= 1'b0;
         req_ready   <= 1'b1;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         mem_req     <= 1'b0;
         mem_wen     <= 1'b0;
         mem_ren     <= 1'b0;
         mem_zero_ex <= 1'b0;
         mem_size    <= BYTE;
         mem_addr    <= '0;
         mem_wdata   <= '0;
      end else begin
         case (state)
            LSU_IDLE: begin
               if (req_valid && req_ready) begin
                  req_ready <= 1'b0;
                  st_q      <= req_we;
                  if (misaligned || out_of_range) begin
                     state     <= LSU_RESP;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_rdata <= '0;
                  end else begin
                     state       <= LSU_ACCESS;
                     mem_req     <= 1'b1;
                     mem_wen     <= req_we;
                     mem_ren     <= !req_we;
                     mem_size    <= req_size;
                     mem_zero_ex <= req_zero_ex;
                     mem_addr    <= ea[AW-1:0];
                     mem_wdata   <= req_wdata;
                  end
               end
            end
            LSU_ACCESS: begin
               mem_req   <= 1'b0;
               mem_wen   <= 1'b0;
               mem_ren   <= 1'b0;
               mem_wdata <= '0;
               if (st_q || SYNC_READ == 0) begin
                  state       <= LSU_RESP;
                  rsp_valid   <= 1'b1;
                  rsp_rdata   <= st_q ? '0 : mem_rdata;
                  mem_addr    <= '0;
                  mem_size    <= BYTE;
                  mem_zero_ex <= 1'b0;
               end else begin
                  // Size/zero_ex stay put: the memory extends the registered data combinationally.
                  state <= LSU_WAIT;
               end
            end
            LSU_WAIT: begin
               state       <= LSU_RESP;
               rsp_valid   <= 1'b1;
               rsp_rdata   <= mem_rdata;
               mem_addr    <= '0;
               mem_size    <= BYTE;
               mem_zero_ex <= 1'b0;
            end
            LSU_RESP: begin
               if (rsp_ready) begin
                  state     <= LSU_IDLE;
                  rsp_valid <= 1'b0;
                  rsp_rdata <= '0;
                  rsp_err   <= 1'b0;
                  req_ready <= 1'b1;
               end
            end
         endcase
      end
   end

`ifdef DMEM_LSU_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (res) begin
         cnt_load  <= '0;
         cnt_store <= '0;
         cnt_err   <= '0;
      end else if (rsp_valid && rsp_ready) begin
         if (rsp_err)   cnt_err   <= cnt_err + 32'd1;
         else if (st_q) cnt_store <= cnt_store + 32'd1;
         else           cnt_load  <= cnt_load + 32'd1;
      end
   end
`endif

endmodule
